// File: rtl/regfile_wb_pkg.sv
// Shared widths, write-back source encoding and the buffered load-result entry
// used by the register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int WB_DATA_WIDTH    = 32;
  localparam int WB_ADDRESS_WIDTH = 5;
  localparam int WB_NUM_REGS      = 32;
  localparam int WB_FIFO_DEPTH    = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_MEM  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [WB_ADDRESS_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding load results that lost write-port arbitration.
// Pushes into a full FIFO and pops from an empty one are ignored.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter  int DEPTH = WB_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     push_entry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t       entries [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = entries[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load/multi-cycle results onto the single register-file write
// port, buffering losing loads and tracking outstanding long-latency writes.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter  int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter  int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
  parameter  int NUM_REGS      = WB_NUM_REGS,
  parameter  int FIFO_DEPTH    = WB_FIFO_DEPTH,
  localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     issue_valid,
  input  logic [ADDRESS_WIDTH-1:0] issue_addr,
  output logic [NUM_REGS-1:0]      busy,
  output logic [CW-1:0]            fifo_count,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] RegWriteAddress,
  output logic [DATA_WIDTH-1:0]    RegWriteData
);

  wb_entry_t           fifo_head;
  wb_entry_t           sel_entry;
  wb_src_e             sel_src;
  logic                fifo_full;
  logic                fifo_empty;
  logic                mem_accept;
  logic                bypass;
  logic                fifo_push;
  logic                fifo_pop;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Ready is a function of occupancy only, so a full FIFO never passes through.
  assign mem_ready  = !fifo_full;
  assign mem_accept = mem_valid && mem_ready;
  assign bypass     = mem_accept && !alu_valid && fifo_empty;
  assign fifo_push  = mem_accept && !bypass;
  assign fifo_pop   = !alu_valid && !fifo_empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry ('{addr: mem_addr, data: mem_data}),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_comb begin
    sel_src   = SRC_NONE;
    sel_entry = '{addr: mem_addr, data: mem_data};
    if (alu_valid) begin
      sel_src   = SRC_ALU;
      sel_entry = '{addr: alu_addr, data: alu_data};
    end else if (!fifo_empty) begin
      sel_src   = SRC_FIFO;
      sel_entry = fifo_head;
    end else if (bypass) begin
      sel_src   = SRC_MEM;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_addr != '0) set_mask = NUM_REGS'(1) << issue_addr;
    if (sel_src == SRC_FIFO || sel_src == SRC_MEM) clr_mask = NUM_REGS'(1) << sel_entry.addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite        <= 1'b0;
      RegWriteAddress <= '0;
      RegWriteData    <= '0;
      busy            <= '0;
    end else begin
      // Writes to x0 are consumed but never enabled; address/data still track.
      if (sel_src != SRC_NONE) begin
        RegWrite        <= (sel_entry.addr != '0);
        RegWriteAddress <= sel_entry.addr;
        RegWriteData    <= sel_entry.data;
      end else begin
        RegWrite        <= 1'b0;
      end
      busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for the register-file write-back arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [31:0] busy;
  logic [2:0]  fifo_count;
  logic        RegWrite;
  logic [4:0]  RegWriteAddress;
  logic [31:0] RegWriteData;

  int asserts_n = 0;
  int fails_n   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .issue_valid     (issue_valid),
    .issue_addr      (issue_addr),
    .busy            (busy),
    .fifo_count      (fifo_count),
    .RegWrite        (RegWrite),
    .RegWriteAddress (RegWriteAddress),
    .RegWriteData    (RegWriteData)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid   = 1'b0;
    alu_addr    = '0;
    alu_data    = '0;
    mem_valid   = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #23;
    asserts_n++; if (RegWrite !== 1'b0) begin fails_n++; $display("FAIL reset_regwrite: got %0h want 0", RegWrite); end
    asserts_n++; if (RegWriteAddress !== 5'd0) begin fails_n++; $display("FAIL reset_addr: got %0h want 0", RegWriteAddress); end
    asserts_n++; if (RegWriteData !== 32'd0) begin fails_n++; $display("FAIL reset_data: got %0h want 0", RegWriteData); end
    asserts_n++; if (busy !== 32'd0) begin fails_n++; $display("FAIL reset_busy: got %0h want 0", busy); end
    rst = 1'b1;
    step();
    // Buffer three loads behind a busy ALU while r12 is marked outstanding.
    issue_valid = 1'b1; issue_addr = 5'd12;
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2;
    step(); step(); step();
    asserts_n++; if (fifo_count !== 3'd3) begin fails_n++; $display("FAIL pre_reset_count: got %0d want 3", fifo_count); end
    asserts_n++; if (busy[12] !== 1'b1) begin fails_n++; $display("FAIL pre_reset_busy12: got %0b want 1", busy[12]); end
    rst = 1'b0;
    #2;
    asserts_n++; if (fifo_count !== 3'd0) begin fails_n++; $display("FAIL midreset_count: got %0d want 0", fifo_count); end
    asserts_n++; if (busy !== 32'd0) begin fails_n++; $display("FAIL midreset_busy: got %0h want 0", busy); end
    asserts_n++; if (RegWrite !== 1'b0 || RegWriteAddress !== 5'd0 || RegWriteData !== 32'd0) begin fails_n++; $display("FAIL midreset_out: got we=%0b a=%0h d=%0h want 0/0/0", RegWrite, RegWriteAddress, RegWriteData); end
    clear_inputs();
    step();
    rst = 1'b1;
    step();
    asserts_n++; if (mem_ready !== 1'b1) begin fails_n++; $display("FAIL postreset_ready: got %0b want 1", mem_ready); end
    asserts_n++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin fails_n++; $display("FAIL postreset_idle: got we=%0b cnt=%0d want 0/0", RegWrite, fifo_count); end
  endtask

  task automatic test_bypass();
    clear_inputs();
    issue_valid = 1'b1; issue_addr = 5'd5;
    step();
    asserts_n++; if (busy[5] !== 1'b1) begin fails_n++; $display("FAIL bypass_busy_set: got %0b want 1", busy[5]); end
    clear_inputs();
    mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'hDEADBEEF;
    asserts_n++; if (mem_ready !== 1'b1) begin fails_n++; $display("FAIL bypass_ready: got %0b want 1", mem_ready); end
    step();
    clear_inputs();
    asserts_n++; if (RegWrite !== 1'b1 || RegWriteAddress !== 5'd5 || RegWriteData !== 32'hDEADBEEF) begin fails_n++; $display("FAIL bypass_write: got we=%0b a=%0d d=%0h want 1/5/deadbeef", RegWrite, RegWriteAddress, RegWriteData); end
    asserts_n++; if (busy[5] !== 1'b0) begin fails_n++; $display("FAIL bypass_busy_clr: got %0b want 0", busy[5]); end
    asserts_n++; if (fifo_count !== 3'd0) begin fails_n++; $display("FAIL bypass_count: got %0d want 0", fifo_count); end
    step();
    asserts_n++; if (RegWrite !== 1'b0 || RegWriteAddress !== 5'd5 || RegWriteData !== 32'hDEADBEEF) begin fails_n++; $display("FAIL idle_hold: got we=%0b a=%0d d=%0h want 0/5/deadbeef", RegWrite, RegWriteAddress, RegWriteData); end
  endtask

  task automatic test_contention();
    clear_inputs();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h22;
    step();
    clear_inputs();
    asserts_n++; if (RegWrite !== 1'b1 || RegWriteAddress !== 5'd3 || RegWriteData !== 32'h11) begin fails_n++; $display("FAIL contention_alu: got we=%0b a=%0d d=%0h want 1/3/11", RegWrite, RegWriteAddress, RegWriteData); end
    asserts_n++; if (fifo_count !== 3'd1) begin fails_n++; $display("FAIL contention_count: got %0d want 1", fifo_count); end
    step();
    asserts_n++; if (RegWrite !== 1'b1 || RegWriteAddress !== 5'd7 || RegWriteData !== 32'h22) begin fails_n++; $display("FAIL contention_mem: got we=%0b a=%0d d=%0h want 1/7/22", RegWrite, RegWriteAddress, RegWriteData); end
    asserts_n++; if (fifo_count !== 3'd0) begin fails_n++; $display("FAIL contention_drained: got %0d want 0", fifo_count); end
    step();
    asserts_n++; if (RegWrite !== 1'b0) begin fails_n++; $display("FAIL contention_idle: got %0b want 0", RegWrite); end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1'b1; alu_addr = 5'(20 + k); alu_data = 32'(k);
      mem_valid = 1'b1;
      mem_addr  = 5'(10 + (k < 4 ? k : 4));
      mem_data  = 32'hA000_0000 + 32'(mem_addr);
      asserts_n++; if (mem_ready !== (k < 4)) begin fails_n++; $display("FAIL bp_ready_%0d: got %0b want %0b", k, mem_ready, (k < 4)); end
      step();
      asserts_n++; if (RegWrite !== 1'b1 || RegWriteAddress !== 5'(20 + k) || RegWriteData !== 32'(k)) begin fails_n++; $display("FAIL bp_alu_%0d: got we=%0b a=%0d d=%0h want 1/%0d/%0h", k, RegWrite, RegWriteAddress, RegWriteData, 20 + k, k); end
      asserts_n++; if (fifo_count !== 3'(k < 3 ? k + 1 : 4)) begin fails_n++; $display("FAIL bp_count_%0d: got %0d want %0d", k, fifo_count, (k < 3 ? k + 1 : 4)); end
    end
    // Full FIFO popping this cycle must still refuse the offered load.
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 5'd14; mem_data = 32'hA000_000E;
    asserts_n++; if (mem_ready !== 1'b0) begin fails_n++; $display("FAIL bp_full_pop_ready: got %0b want 0", mem_ready); end
    for (int d = 0; d < 4; d++) begin
      step();
      clear_inputs();
      asserts_n++; if (RegWrite !== 1'b1 || RegWriteAddress !== 5'(10 + d) || RegWriteData !== 32'hA000_0000 + 32'(10 + d)) begin fails_n++; $display("FAIL bp_drain_%0d: got we=%0b a=%0d d=%0h want 1/%0d/%0h", d, RegWrite, RegWriteAddress, RegWriteData, 10 + d, 32'hA000_0000 + 32'(10 + d)); end
    end
    step();
    asserts_n++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin fails_n++; $display("FAIL bp_after_drain: got we=%0b cnt=%0d want 0/0", RegWrite, fifo_count); end
  endtask

  task automatic test_x0();
    clear_inputs();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h66;
    issue_valid = 1'b1; issue_addr = 5'd0;
    step();
    clear_inputs();
    asserts_n++; if (RegWrite !== 1'b0) begin fails_n++; $display("FAIL x0_alu_we: got %0b want 0", RegWrite); end
    asserts_n++; if (fifo_count !== 3'd1) begin fails_n++; $display("FAIL x0_count: got %0d want 1", fifo_count); end
    asserts_n++; if (busy !== 32'd0) begin fails_n++; $display("FAIL x0_busy: got %0h want 0", busy); end
    step();
    asserts_n++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin fails_n++; $display("FAIL x0_fifo_pop: got we=%0b cnt=%0d want 0/0", RegWrite, fifo_count); end
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h77;
    step();
    clear_inputs();
    asserts_n++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin fails_n++; $display("FAIL x0_bypass: got we=%0b cnt=%0d want 0/0", RegWrite, fifo_count); end
  endtask

  task automatic test_scoreboard_race();
    clear_inputs();
    issue_valid = 1'b1; issue_addr = 5'd9;
    step();
    asserts_n++; if (busy[9] !== 1'b1) begin fails_n++; $display("FAIL race_busy_set: got %0b want 1", busy[9]); end
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
    step();
    clear_inputs();
    asserts_n++; if (RegWrite !== 1'b1 || RegWriteAddress !== 5'd9) begin fails_n++; $display("FAIL race_write: got we=%0b a=%0d want 1/9", RegWrite, RegWriteAddress); end
    asserts_n++; if (busy[9] !== 1'b1) begin fails_n++; $display("FAIL race_set_wins: got %0b want 1", busy[9]); end
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h9A;
    step();
    clear_inputs();
    asserts_n++; if (busy !== 32'd0) begin fails_n++; $display("FAIL race_busy_clr: got %0h want 0", busy); end
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h1;
    issue_valid = 1'b1; issue_addr = 5'd4;
    step();
    clear_inputs();
    asserts_n++; if (busy !== 32'h10) begin fails_n++; $display("FAIL alu_no_busy: got %0h want 10", busy); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_contention();
    test_backpressure();
    test_x0();
    test_scoreboard_race();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fails_n);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back side of the integer register file: merges single-cycle ALU results and variable-latency load/multi-cycle results into the register file's single write port (RegWrite / RegWriteAddress / RegWriteData). A small FIFO buffers load results that lose arbitration. A per-register busy scoreboard lets the hazard unit stall on registers with an outstanding long-latency write. Outputs are registered on posedge clk, so they are stable when the register file samples them on the following negedge.

## Interface
- DATA_WIDTH, 32, bits per register/result
- ADDRESS_WIDTH, 5, register address width
- NUM_REGS, 32, registers tracked by scoreboard
- FIFO_DEPTH, 4, load-result buffer entries (power of two, ≥2)

- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- alu_valid  in  1  ALU result present this cycle; never stalled
- alu_addr  in  ADDRESS_WIDTH  ALU destination
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load/multi-cycle result offered
- mem_ready  out  1  result accepted when mem_valid && mem_ready
- mem_addr  in  ADDRESS_WIDTH  load destination
- mem_data  in  DATA_WIDTH  load result
- issue_valid  in  1  long-latency op issued this cycle
- issue_addr  in  ADDRESS_WIDTH  its destination
- busy  out  NUM_REGS  bit r=1: write to r outstanding
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries
- RegWrite  out  1  write enable to register file
- RegWriteAddress  out  ADDRESS_WIDTH  write address
- RegWriteData  out  DATA_WIDTH  write data

## Operation
- At most one write emitted per cycle; fixed priority: ALU > FIFO head > direct mem (bypass).
- mem_ready = (fifo_count < FIFO_DEPTH); depends on count only, never on alu_valid.
- Accepted mem result: bypasses to output iff alu_valid=0 and FIFO empty; otherwise enqueued at tail.
- FIFO head dequeued and emitted whenever alu_valid=0. Load results retire in acceptance order.
- Address 0: write consumed (dequeued/accepted) but RegWrite stays 0; busy[0] always 0.
- Scoreboard: issue_valid && issue_addr≠0 sets busy[issue_addr]; emitting a mem-sourced write (FIFO or bypass) clears busy[addr]. Same-cycle set and clear of one address: set wins. ALU writes never touch busy.
- ALU write to a register with busy=1 is a contract violation (hazard unit stalls); block does not reorder or check.

## Timing
- Reset (rst=0, async): RegWrite=0, RegWriteAddress=0, RegWriteData=0, busy=0, FIFO flushed, fifo_count=0, mem_ready=1 once rst deasserts. Reset mid-drain discards buffered entries.
- Latency: input in cycle N → RegWrite=1 with that addr/data throughout cycle N+1; register file captures at negedge of N+1.
- Idle cycle (nothing selected): RegWrite=0; address/data hold previous values.
- Full FIFO: mem_ready=0 even if a dequeue occurs the same cycle (no pass-through when full).
- Continuous alu_valid starves FIFO; mem_ready drops after FIFO_DEPTH accepted loads.
- busy update visible the cycle after issue/emission.

## Structure
- Package regfile_wb_pkg: default widths/depth, enum wb_src_e {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_MEM}, packed struct wb_entry_t {addr, data}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t, push/pop/full/empty/count, async active-low reset.
- Top: arbitration mux, output register, scoreboard register.

## Test plan
- Reset: rst=0 mid-stream with 3 entries buffered → outputs 0, busy=0, fifo_count=0; after release mem_ready=1.
- Bypass: mem_valid, addr=5, data=0xDEADBEEF, FIFO empty, alu idle → next cycle RegWrite=1, addr 5, data 0xDEADBEEF; busy[5] set by earlier issue clears.
- Contention: alu (3,0x11) and mem (7,0x22) same cycle → cycle+1 writes r3=0x11, cycle+2 writes r7=0x22.
- Backpressure: alu_valid held 6 cycles, mem_valid continuous → 4 accepted, mem_ready=0, then drain r-order preserved one per cycle after alu stops.
- x0: alu_addr=0 and mem_addr=0 → RegWrite never 1, FIFO consumes entry, busy[0]=0.
- Scoreboard race: issue_addr=9 same cycle as emitted mem write to r9 → busy[9]=1 next cycle.
